// File: rtl/uart_status_framer_pkg.sv
// Shared definitions for the UART status framer: frame constants, FSM state
// encoding, settings snapshot layout and the frame checksum.
package uart_status_framer_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned FRAME_LEN       = 10;
    localparam int unsigned IDX_W           = 4;
    localparam int unsigned TIMEOUT_CYC_DEF = 20000;

    localparam logic [BYTE_W-1:0] HDR0   = 8'h55;
    localparam logic [BYTE_W-1:0] HDR1   = 8'hAA;
    localparam logic [BYTE_W-1:0] CMD_ID = 8'hA1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Video-control settings captured at frame start.
    typedef struct packed {
        logic [11:0] x_pix_len;
        logic [11:0] y_pix_len;
        logic [1:0]  algorithm;
        logic        vid_format;
        logic [8:0]  bi_a;
    } status_snap_t;

    // 8-bit wrap-around sum of payload bytes 2..8 (CMD_ID through bi_a low byte).
    function automatic logic [BYTE_W-1:0] frame_checksum(input status_snap_t s);
        logic [BYTE_W-1:0] sum;
        sum = CMD_ID;
        sum = sum + {4'b0, s.x_pix_len[11:8]};
        sum = sum + s.x_pix_len[7:0];
        sum = sum + {4'b0, s.y_pix_len[11:8]};
        sum = sum + s.y_pix_len[7:0];
        sum = sum + {4'b0, s.algorithm, s.vid_format, s.bi_a[8]};
        sum = sum + s.bi_a[7:0];
        return sum;
    endfunction

endpackage

// File: rtl/uart_status_framer_if.sv
// Byte-level handshake between the status framer and the UART transmitter.
//   txd_en   : framer -> tx, one-cycle start pulse for txd_data
//   txd_data : framer -> tx, byte to send, stable until the next txd_en
//   txd_flag : tx -> framer, one-cycle pulse when the byte has been sent
interface uart_status_framer_if;
    import uart_status_framer_pkg::*;

    logic              txd_en;
    logic [BYTE_W-1:0] txd_data;
    logic              txd_flag;

    modport master (output txd_en, output txd_data, input txd_flag);
    modport slave  (input txd_en, input txd_data, output txd_flag);
endinterface

// File: rtl/uart_status_framer.sv
// Builds a 10-byte checksummed status frame from the current video settings
// and streams it one byte at a time to the UART transmitter, with an
// acknowledge timeout that aborts a stalled frame.
// Ports:
//   sys_clk, sys_rst_n  : clock, async active-low reset
//   pix_len_update      : settings-changed pulse, requests a frame
//   status_req          : host status request pulse, requests a frame
//   x_pix_len..bi_a     : live settings, snapshotted at frame start
//   txd_if              : transmitter byte handshake (master side)
//   busy                : frame in progress
//   frame_done          : pulse, last byte acknowledged
//   timeout_err         : pulse, frame aborted waiting for txd_flag
module uart_status_framer
    import uart_status_framer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        pix_len_update,
    input  logic                        status_req,
    input  logic [11:0]                 x_pix_len,
    input  logic [11:0]                 y_pix_len,
    input  logic [1:0]                  algorithm,
    input  logic                        vid_format,
    input  logic [8:0]                  bi_a,
    uart_status_framer_if.master        txd_if,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pending_q, pending_d;
    status_snap_t       snap_q, snap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               txd_en_q, txd_en_d;
    logic [BYTE_W-1:0]  txd_data_q, txd_data_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               timeout_err_q, timeout_err_d;
    logic               trig_c;

    // Byte multiplexer over the frozen snapshot.
    function automatic logic [BYTE_W-1:0] frame_byte(input logic [IDX_W-1:0] idx,
                                                     input status_snap_t s);
        case (idx)
            4'd0:    return HDR0;
            4'd1:    return HDR1;
            4'd2:    return CMD_ID;
            4'd3:    return {4'b0, s.x_pix_len[11:8]};
            4'd4:    return s.x_pix_len[7:0];
            4'd5:    return {4'b0, s.y_pix_len[11:8]};
            4'd6:    return s.y_pix_len[7:0];
            4'd7:    return {4'b0, s.algorithm, s.vid_format, s.bi_a[8]};
            4'd8:    return s.bi_a[7:0];
            4'd9:    return frame_checksum(s);
            default: return 8'h00;
        endcase
    endfunction

    assign trig_c = pix_len_update | status_req;

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            snap_q        <= '0;
            cnt_q         <= '0;
            txd_en_q      <= 1'b0;
            txd_data_q    <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            snap_q        <= snap_d;
            cnt_q         <= cnt_d;
            txd_en_q      <= txd_en_d;
            txd_data_q    <= txd_data_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pending_d     = pending_q;
        snap_d        = snap_q;
        cnt_d         = cnt_q;
        txd_en_d      = 1'b0;
        txd_data_d    = txd_data_q;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (trig_c || pending_q) begin
                    snap_d.x_pix_len  = x_pix_len;
                    snap_d.y_pix_len  = y_pix_len;
                    snap_d.algorithm  = algorithm;
                    snap_d.vid_format = vid_format;
                    snap_d.bi_a       = bi_a;
                    pending_d  = 1'b0;
                    idx_d      = '0;
                    txd_en_d   = 1'b1;
                    txd_data_d = HDR0;
                    state_d    = WAIT;
                end
            end

            WAIT: begin
                if (trig_c) begin
                    pending_d = 1'b1;
                end
                // An acknowledge coinciding with our own txd_en belongs to no byte.
                if (txd_if.txd_flag && !txd_en_q) begin
                    if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                        frame_done_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        txd_en_d   = 1'b1;
                        txd_data_d = frame_byte(idx_q + IDX_W'(1), snap_q);
                        cnt_d      = '0;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (trig_c) begin
                    pending_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == WAIT);
    end

    assign txd_if.txd_en   = txd_en_q;
    assign txd_if.txd_data = txd_data_q;
    assign busy            = busy_q;
    assign frame_done      = frame_done_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: doc/uart_status_framer.md
Name: uart_status_framer

Overview:
Builds a fixed 10-byte status frame from the current video-control settings and sends it one byte at a time over the byte-level UART transmitter handshake (txd_en / txd_data / txd_flag).
- Sits downstream of the UART command decoder, consuming its pixel lengths, algorithm, vid_format, bi_a and update pulse.
- Sits upstream of the UART transmitter on the control link.
- Replaces the ad-hoc two-byte echo logic with a framed, checksummed report that includes timeout recovery.

Parameters:
HDR0, 8'h55, first header byte
HDR1, 8'hAA, second header byte
CMD_ID, 8'hA1, frame type byte
TIMEOUT_CYC, 20000, sys_clk cycles to wait for txd_flag before aborting (one byte at 115200 bps on 96 MHz is about 8333 cycles)

Ports:
sys_clk  in  1  system clock (96 MHz)
sys_rst_n  in  1  reset, asynchronous, active-low; the block has one clock only
pix_len_update  in  1  one-cycle pulse: settings changed, send a frame
status_req  in  1  one-cycle pulse: host asked for status, send a frame
x_pix_len  in  12  horizontal output length
y_pix_len  in  12  vertical output length
algorithm  in  2  scaler algorithm select
vid_format  in  1  video format flag
bi_a  in  9  interpolation coefficient
txd_flag  in  1  one-cycle pulse from the transmitter: byte sent
txd_en  out  1  one-cycle pulse: start sending txd_data
txd_data  out  8  byte to send; held stable until the next txd_en
busy  out  1  a frame is in progress
frame_done  out  1  one-cycle pulse: last byte acknowledged
timeout_err  out  1  one-cycle pulse: frame aborted on timeout

Behaviour:
- Reset values: txd_en=0, txd_data=0, busy=0, frame_done=0, timeout_err=0, pending=0, byte index=0, state=IDLE, snapshot registers=0.
- Trigger: trig = pix_len_update | status_req. If both are high in the same cycle, they count as one trigger.
- Frame layout, byte 0 to byte 9:
  - byte 0 = HDR0, byte 1 = HDR1, byte 2 = CMD_ID
  - byte 3 = {4'b0, x[11:8]}, byte 4 = x[7:0]
  - byte 5 = {4'b0, y[11:8]}, byte 6 = y[7:0]
  - byte 7 = {4'b0, algorithm, vid_format, bi_a[8]}, byte 8 = bi_a[7:0]
  - byte 9 = checksum = sum of bytes 2 to 8, mod 256
- Snapshot: all inputs are registered in the cycle the frame starts. Input changes during a frame do not affect it.
- States:
  - IDLE, busy=0. On trig, or on pending=1:
    - take the snapshot and clear pending;
    - next cycle: txd_en=1 and txd_data=HDR0;
    - index=0, go to WAIT.
    - Latency: a trigger sampled in cycle T gives txd_en high in cycle T+1.
  - WAIT, busy=1.
    - txd_flag is ignored in the cycle where txd_en is high.
    - On txd_flag with index<9: index++, and in the next cycle txd_en=1 with the next byte.
    - On txd_flag with index==9: go to DONE.
    - The timeout counter clears on every txd_en. When it reaches TIMEOUT_CYC-1 without a txd_flag: pulse timeout_err, go to IDLE, and leave txd_data unchanged.
  - DONE: pulse frame_done for one cycle, busy=0, go to IDLE.
    - If pending=1, a new frame starts from IDLE with txd_en one cycle later.
- A trigger while busy sets pending. Multiple triggers collapse into one pending frame.
- A trigger in the same cycle as the final txd_flag or as the timeout also sets pending.
- txd_en is never asserted while waiting for an acknowledge. At most one byte is outstanding at a time.
- Reset mid-frame: everything returns to its reset value immediately and no further txd_en is issued.

Decomposition:
- Shared package holds: FRAME_LEN=10, the header and CMD_ID defaults, the state encoding (IDLE, WAIT, DONE) and a checksum function (8-bit sum over bytes 2 to 8).
- No sub-module; the byte multiplexer is a case on the index inside the block.

Test Plan:
- Basic frame, x=1920, y=1080, algorithm=2, vid_format=1, bi_a=500; pulse pix_len_update; transmitter model acknowledges each byte after 8333 cycles -> bytes 55 AA A1 07 80 04 38 0B F4 63, frame_done pulses once after the 10th acknowledge.
- Latency: status_req pulses in cycle T -> txd_en=1 in cycle T+1 with txd_data=8'h55. After an acknowledge in cycle A, the next txd_en is in cycle A+1.
- Snapshot: change x_pix_len to 1280 after byte 2 has been acknowledged -> bytes 3 and 4 still read 07 80.
- Pending: three triggers during a frame, with x changed to 1280 -> exactly one extra frame starts the cycle after DONE, carrying bytes 05 00.
- Timeout: withhold txd_flag after byte 4 -> timeout_err pulses TIMEOUT_CYC cycles after that byte's txd_en, busy=0, no frame_done. A following trigger sends a full frame.
- Reset: assert sys_rst_n=0 during byte 6 -> all outputs are 0 immediately. After release, no txd_en until a new trigger arrives.
